crc8_serial_checker: RTL

//  Receive-side partner of the serial CRC-8 generator. Recomputes the CRC over
//  a serial message (DATA while Active), then compares the 8 trailing CRC bits
//  (CRC_IN while CRC_VLD, LSB first) against the computed value.

---
 rtl/crc8_serial_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/crc8_serial_checker.sv
// crc8_serial_checker
//   Receive-side CRC-8 checker. Recomputes the CRC over a serial message
//   (DATA qualified by Active) and compares the 8 trailing received CRC bits
//   (CRC_IN qualified by CRC_VLD, LSB first) against it.
//   One Done pulse per completed frame, with a held Pass verdict and message
//   length. Optional build macro CRC_CHK_SYNDROME_EN adds a held Syndrome
//   output (expected ^ received CRC).
module crc8_serial_checker #(
  parameter logic [7:0] SEED  = 8'hD8,
  parameter int         LEN_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             DATA,
  input  logic             Active,
  input  logic             CRC_IN,
  input  logic             CRC_VLD,
  output logic             Done,
  output logic             Pass,
  output logic [LEN_W-1:0] Msg_Len
`ifdef CRC_CHK_SYNDROME_EN
  ,
  output logic [7:0]       Syndrome
`endif
);

  typedef enum logic [1:0] {IDLE, MSG, CHK} state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [2:0]         idx_q, idx_d;
  logic               mis_q, mis_d;
  logic               done_d, pass_d;
  logic [LEN_W-1:0]   msg_len_d;
  logic               diff;
`ifdef CRC_CHK_SYNDROME_EN
  logic [7:0]         syn_sr_q, syn_sr_d;
  logic [7:0]         syndrome_d;
`endif

  // One serial LFSR step with message bit d.
  function automatic logic [7:0] crc_step(input logic [7:0] l, input logic d);
    logic fb;
    fb = l[0] ^ d;
    return {fb, l[7] ^ fb, l[6:4], l[3] ^ fb, l[2:1]};
  endfunction

  assign diff = CRC_IN ^ lfsr_q[0];

  // Next-state and datapath decode; Active has priority over CRC_VLD.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    mis_d      = mis_q;
    done_d     = 1'b0;
    pass_d     = Pass;
    msg_len_d  = Msg_Len;
`ifdef CRC_CHK_SYNDROME_EN
    syn_sr_d   = syn_sr_q;
    syndrome_d = Syndrome;
`endif
    unique case (state_q)
      IDLE: begin
        if (Active) begin
          lfsr_d  = crc_step(SEED, DATA);
          len_d   = LEN_W'(1);
          idx_d   = 3'd0;
          mis_d   = 1'b0;
          state_d = MSG;
        end
      end
      MSG: begin
        if (Active) begin
          lfsr_d = crc_step(lfsr_q, DATA);
          if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
        end else if (CRC_VLD) begin
          lfsr_d   = lfsr_q >> 1;
          idx_d    = 3'd1;
          mis_d    = diff;
`ifdef CRC_CHK_SYNDROME_EN
          syn_sr_d = {diff, 7'd0};
`endif
          state_d  = CHK;
        end
      end
      CHK: begin
        if (Active) begin
          // Abort: restart a fresh frame with this bit, verdict untouched.
          lfsr_d  = crc_step(SEED, DATA);
          len_d   = LEN_W'(1);
          idx_d   = 3'd0;
          mis_d   = 1'b0;
          state_d = MSG;
        end else if (CRC_VLD) begin
          lfsr_d   = lfsr_q >> 1;
          mis_d    = mis_q | diff;
`ifdef CRC_CHK_SYNDROME_EN
          syn_sr_d = {diff, syn_sr_q[7:1]};
`endif
          if (idx_q == 3'd7) begin
            done_d     = 1'b1;
            pass_d     = ~(mis_q | diff);
            msg_len_d  = len_q;
`ifdef CRC_CHK_SYNDROME_EN
            syndrome_d = {diff, syn_sr_q[7:1]};
`endif
            idx_d      = 3'd0;
            state_d    = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      len_q    <= '0;
      idx_q    <= 3'd0;
      mis_q    <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      Msg_Len  <= '0;
`ifdef CRC_CHK_SYNDROME_EN
      syn_sr_q <= 8'h00;
      Syndrome <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      Done     <= done_d;
      Pass     <= pass_d;
      Msg_Len  <= msg_len_d;
`ifdef CRC_CHK_SYNDROME_EN
      syn_sr_q <= syn_sr_d;
      Syndrome <= syndrome_d;
`endif
    end
  end

endmodule
